// File: rtl/alu4_acc_ctrl_if.sv
// alu4_acc_ctrl_if: command and result handshake channels of the ALU accumulator stage
interface alu4_acc_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic [2:0] in_op;
  logic [3:0] in_opnd;
  logic in_load;
  logic in_clr;
  logic out_valid;
  logic out_ready;
  logic [3:0] out_acc;
  logic [3:0] out_flags;
  modport master (
    output in_valid, in_op, in_opnd, in_load, in_clr, out_ready,
    input in_ready, out_valid, out_acc, out_flags
  );
  modport slave (
    input in_valid, in_op, in_opnd, in_load, in_clr, out_ready,
    output in_ready, out_valid, out_acc, out_flags
  );
endinterface

// File: rtl/alu4_acc_ctrl.sv
// alu4_acc_ctrl: sequences one command per handshake through the external 4-bit ALU into an NZCV accumulator
module alu4_acc_ctrl #(
  parameter logic [3:0] ACC_INIT = 4'h0,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  alu4_acc_ctrl_if.slave bus,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input logic [3:0] alu_y,
  input logic alu_co,
  input logic alu_vo,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [3:0] FLAGS_INIT = (ACC_INIT == 4'h0) ? 4'b0100 : {ACC_INIT[3], 3'b000};
  state_t state, state_nxt;
  logic [3:0] acc, flags, acc_nxt, flags_nxt;
  logic load, accept;
  assign alu_a = acc;
  assign bus.out_acc = acc;
  assign bus.out_flags = flags;
  assign bus.out_valid = state == DONE;
  assign bus.in_ready = state == IDLE && !bus.in_clr;
  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? DONE :
                state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
    acc_nxt = load ? alu_b : alu_y;
    flags_nxt = {acc_nxt[3], acc_nxt == 4'h0, !load && alu_co, !load && alu_vo};
  end
  // clear and accept are mutually exclusive because in_ready is masked by in_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= ACC_INIT;
      flags <= FLAGS_INIT;
      alu_b <= 4'h0;
      alu_sel <= 3'h0;
      load <= 1'b0;
      op_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.in_clr) begin
        acc <= ACC_INIT;
        flags <= FLAGS_INIT;
        op_cnt <= '0;
      end
      if (accept) begin
        alu_sel <= bus.in_op;
        alu_b <= bus.in_opnd;
        load <= bus.in_load;
      end
      if (state == EXEC) begin
        acc <= acc_nxt;
        flags <= flags_nxt;
      end
      if (state == DONE && bus.out_ready) op_cnt <= op_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// tb_alu4_acc_ctrl: directed scoreboard bench for alu4_acc_ctrl with a stub ALU driven per step
module tb_alu4_acc_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  alu4_acc_ctrl_if bus();
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;
  logic alu_co, alu_vo;
  logic [7:0] op_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];
  logic [3:0] m_acc;
  logic [7:0] m_cnt;
  logic [3:0] m_b;
  alu4_acc_ctrl #(.ACC_INIT(4'h0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_co(alu_co), .alu_vo(alu_vo), .op_cnt(op_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] fl(input logic [3:0] a, input logic c, input logic v);
    return {a[3], a == 4'h0, c, v};
  endfunction
  task automatic sb_pop(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed output with empty scoreboard, expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, bus.out_acc, e[7:4]);
      chk({tag, "_flags"}, bus.out_flags, e[3:0]);
    end
  endtask
  task automatic start(input logic ld, input logic [2:0] op, input logic [3:0] b,
                       input logic [3:0] y, input logic co, input logic vo);
    logic [3:0] a_old;
    a_old = m_acc;
    bus.in_valid = 1'b1;
    bus.in_load = ld;
    bus.in_op = op;
    bus.in_opnd = b;
    alu_y = y;
    alu_co = co;
    alu_vo = vo;
    m_acc = ld ? b : y;
    m_b = b;
    sb.push_back({m_acc, fl(m_acc, ld ? 1'b0 : co, ld ? 1'b0 : vo)});
    tick();
    bus.in_valid = 1'b0;
    chk("exec_alu_a", alu_a, a_old);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_sel", alu_sel, op);
    chk("exec_out_valid", bus.out_valid, 0);
    chk("exec_in_ready", bus.in_ready, 0);
  endtask
  task automatic finish_op(input string tag);
    tick();
    chk({tag, "_valid"}, bus.out_valid, 1);
    sb_pop(tag);
  endtask
  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    m_cnt++;
    chk("hs_op_cnt", op_cnt, m_cnt);
    chk("hs_idle_valid", bus.out_valid, 0);
    chk("hs_idle_ready", bus.in_ready, 1);
  endtask
  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = 3'h0;
    bus.in_opnd = 4'h0;
    bus.in_load = 1'b0;
    bus.in_clr = 1'b0;
    bus.out_ready = 1'b0;
    alu_y = 4'h0;
    alu_co = 1'b0;
    alu_vo = 1'b0;
    m_acc = 4'h0;
    m_cnt = 8'h0;
    m_b = 4'h0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc", bus.out_acc, 0);
    chk("rst_flags", bus.out_flags, 4'b0100);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    // reset in the middle of an operation
    start(1'b1, 3'h0, 4'h7, 4'h0, 1'b0, 1'b0);
    finish_op("load7");
    handshake();
    bus.in_valid = 1'b1;
    bus.in_load = 1'b0;
    bus.in_op = 3'h3;
    bus.in_opnd = 4'h2;
    alu_y = 4'hE;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_exec_alu_a", alu_a, 4'h7);
    reset = 1'b1;
    #1;
    chk("abort_acc", bus.out_acc, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_op_cnt", op_cnt, 0);
    chk("abort_flags", bus.out_flags, 4'b0100);
    m_acc = 4'h0;
    m_cnt = 8'h0;
    reset = 1'b0;
    tick();
    chk("abort_stay_idle", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    // direct load
    start(1'b1, 3'h0, 4'h9, 4'h3, 1'b1, 1'b1);
    finish_op("load9");
    handshake();
    // ALU op using carry and overflow from the ALU
    start(1'b0, 3'b010, 4'h7, 4'h0, 1'b1, 1'b1);
    finish_op("alu010");
    // backpressure with a pending command and an ignored clear
    bus.in_valid = 1'b1;
    bus.in_load = 1'b1;
    bus.in_opnd = 4'h5;
    for (int i = 0; i < 5; i++) begin
      bus.in_clr = (i == 2);
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_acc", bus.out_acc, 4'h0);
      chk("bp_flags", bus.out_flags, 4'b0111);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_clr = 1'b0;
    bus.in_valid = 1'b0;
    handshake();
    chk("bp_not_accepted", alu_b, 4'h7);
    // second ALU op: negative result, V set, C clear
    start(1'b0, 3'b101, 4'h3, 4'hC, 1'b0, 1'b1);
    finish_op("alu101");
    handshake();
    // clear collides with a valid command
    bus.in_clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_load = 1'b1;
    bus.in_opnd = 4'hB;
    #1;
    chk("clr_in_ready", bus.in_ready, 0);
    tick();
    chk("clr_no_op", bus.out_valid, 0);
    chk("clr_acc", bus.out_acc, 0);
    chk("clr_flags", bus.out_flags, 4'b0100);
    chk("clr_op_cnt", op_cnt, 0);
    chk("clr_alu_b", alu_b, m_b);
    bus.in_clr = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("clr_still_idle", bus.out_valid, 0);
    m_acc = 4'h0;
    m_cnt = 8'h0;
    // back-to-back loads wrapping the op counter
    for (int i = 0; i < 256; i++) begin
      start(1'b1, 3'h1, 4'(i * 7 + 1), 4'h0, 1'b1, 1'b1);
      finish_op("b2b");
      handshake();
      if (i == 254) chk("b2b_cnt_max", op_cnt, 8'hFF);
    end
    chk("b2b_cnt_wrap", op_cnt, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
